cmp_slice_sequencer: RTL and testbench

//   Compares two WIDTH-bit operands by stepping through 2-bit slices, most

---
 rtl/cmp_slice_sequencer.sv | 128 ++++++++++++
 tb/tb_cmp_slice_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_slice_sequencer.sv
// Multi-cycle wide comparator: walks operands MSB-first in 2-bit slices through an external comparator.
// Optional macro CMP_SEQ_CHECK_EN: flags a non-one-hot comparator response (sticky err) and aborts the compare.
module cmp_slice_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    input  logic             slice_gt,
    input  logic             slice_eq,
    input  logic             slice_lt,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             err
);

    localparam int NSLICE = WIDTH / 2;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state;
    logic [IDXW-1:0]  r_idx, w_idx;
    logic [WIDTH-1:0] r_opa, w_opa;
    logic [WIDTH-1:0] r_opb, w_opb;
    logic             r_gt, w_gt;
    logic             r_eq, w_eq;
    logic             r_lt, w_lt;
    logic             r_err, w_err;
    logic             w_bad;

`ifdef CMP_SEQ_CHECK_EN
    assign w_bad = ({slice_gt, slice_eq, slice_lt} != 3'b100) &&
                   ({slice_gt, slice_eq, slice_lt} != 3'b010) &&
                   ({slice_gt, slice_eq, slice_lt} != 3'b001);
`else
    assign w_bad = 1'b0;
`endif

    assign slice_a = r_opa[{r_idx, 1'b0} +: 2];
    assign slice_b = r_opb[{r_idx, 1'b0} +: 2];
    assign busy    = (r_state == S_SCAN);
    assign done    = (r_state == S_DONE);
    assign a_gt_b  = r_gt;
    assign a_eq_b  = r_eq;
    assign a_lt_b  = r_lt;
    assign err     = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= IDX_TOP;
            r_opa   <= '0;
            r_opb   <= '0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_opa   <= w_opa;
            r_opb   <= w_opb;
            r_gt    <= w_gt;
            r_eq    <= w_eq;
            r_lt    <= w_lt;
            r_err   <= w_err;
        end
    end

    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_opa   = r_opa;
        w_opb   = r_opb;
        w_gt    = r_gt;
        w_eq    = r_eq;
        w_lt    = r_lt;
        w_err   = r_err;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state = S_SCAN;
                    w_idx   = IDX_TOP;
                    w_opa   = a_in;
                    w_opb   = b_in;
                    w_gt    = 1'b0;
                    w_eq    = 1'b0;
                    w_lt    = 1'b0;
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_SCAN: begin
                // No flag at all counts as equal, so the idx==0 test does not require slice_eq.
                if (w_bad) begin
                    w_err   = 1'b1;
                    w_state = S_DONE;
                end else if (slice_gt) begin
                    w_gt    = 1'b1;
                    w_state = S_DONE;
                end else if (slice_lt) begin
                    w_lt    = 1'b1;
                    w_state = S_DONE;
                end else if (r_idx == '0) begin
                    w_eq    = 1'b1;
                    w_state = S_DONE;
                end else begin
                    w_idx   = r_idx - 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cmp_slice_sequencer.sv
// Bench for cmp_slice_sequencer (WIDTH=8): directed and random compares against a whole-operand reference model.
module tb_cmp_slice_sequencer;

    localparam int WIDTH  = 8;
    localparam int NSLICE = WIDTH / 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in, b_in;
    logic [1:0]       slice_a, slice_b;
    logic             slice_gt, slice_eq, slice_lt;
    logic             busy, done, a_gt_b, a_eq_b, a_lt_b, err;
    logic             force_both;

    int checks = 0;
    int errors = 0;
    logic exp_err_sticky = 1'b0;

    cmp_slice_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .slice_a(slice_a), .slice_b(slice_b),
        .slice_gt(slice_gt), .slice_eq(slice_eq), .slice_lt(slice_lt),
        .busy(busy), .done(done), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b),
        .a_lt_b(a_lt_b), .err(err)
    );

    // Reference 2-bit comparator, with an override that asserts gt and lt together.
    assign slice_gt = force_both | (slice_a > slice_b);
    assign slice_lt = force_both | (slice_a < slice_b);
    assign slice_eq = !force_both && (slice_a == slice_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-word result; latency is how many MSB-first slices are needed to find a difference.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic g, output logic e, output logic l, output int lat);
        logic [WIDTH-1:0] x;
        int p;
        g = (a > b);
        e = (a == b);
        l = (a < b);
        x = a ^ b;
        p = -1;
        for (int i = 0; i < WIDTH; i++) if (x[i]) p = i;
        lat = (p < 0) ? NSLICE : NSLICE - (p / 2);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit hold);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Returns at the negedge where done is high (or after the cycle budget).
    task automatic wait_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic eg, input logic ee, input logic el,
                               input int lat, input bit pulse);
        int  nb;
        bit  seen;
        nb   = 0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) begin
                nb++;
                if (nb <= NSLICE) begin
                    chk("slice_a", {30'd0, slice_a}, 32'((a >> (2 * (NSLICE - nb))) & 3));
                    chk("slice_b", {30'd0, slice_b}, 32'((b >> (2 * (NSLICE - nb))) & 3));
                end
                if (pulse && nb == 1) begin
                    start = 1'b1;
                    a_in  = ~a;
                    b_in  = a;
                end
                if (pulse && nb == 2) start = 1'b0;
            end
            @(negedge clk);
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("busy_cycles", nb, lat);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        chk("a_gt_b", {31'd0, a_gt_b}, {31'd0, eg});
        chk("a_eq_b", {31'd0, a_eq_b}, {31'd0, ee});
        chk("a_lt_b", {31'd0, a_lt_b}, {31'd0, el});
        chk("err", {31'd0, err}, {31'd0, exp_err_sticky});
    endtask

    task automatic after_done(input logic eg, input logic ee, input logic el);
        @(negedge clk);
        chk("done_pulse_end", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("hold_flags", {29'd0, a_gt_b, a_eq_b, a_lt_b}, {29'd0, eg, ee, el});
    endtask

    task automatic full_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic g, e, l;
        int lat;
        model(a, b, g, e, l, lat);
        start_cmp(a, b, 1'b0);
        wait_result(a, b, g, e, l, lat, 1'b0);
        after_done(g, e, l);
    endtask

    initial begin
        logic g, e, l, g2, e2, l2;
        int lat, lat2;
        logic [WIDTH-1:0] ra, rb;

        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; force_both = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_flags", {28'd0, a_gt_b, a_eq_b, a_lt_b, err}, 32'd0);
        chk("rst_slices", {28'd0, slice_a, slice_b}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a scan.
        start_cmp(8'h12, 8'h13, 1'b0);
        chk("mid_busy_e1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("mid_busy_e2", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_flags", {28'd0, a_gt_b, a_eq_b, a_lt_b, err}, 32'd0);
        chk("midrst_slices", {28'd0, slice_a, slice_b}, 32'd0);
        @(negedge clk);

        // Directed compares: early gt, second-slice lt, full-length eq and lt.
        full_cmp(8'hC5, 8'h35);
        full_cmp(8'h40, 8'h7F);
        full_cmp(8'h5A, 8'h5A);
        full_cmp(8'h12, 8'h13);

        // start held high through DONE: second compare accepted on the DONE cycle.
        model(8'h9C, 8'h9D, g, e, l, lat);
        model(8'h3E, 8'h3E, g2, e2, l2, lat2);
        start_cmp(8'h9C, 8'h9D, 1'b1);
        wait_result(8'h9C, 8'h9D, g, e, l, lat, 1'b0);
        start_cmp(8'h3E, 8'h3E, 1'b0);
        wait_result(8'h3E, 8'h3E, g2, e2, l2, lat2, 1'b0);
        after_done(g2, e2, l2);

        // start pulsed during SCAN is ignored; slices keep tracking the latched operands.
        model(8'h5A, 8'h5A, g, e, l, lat);
        start_cmp(8'h5A, 8'h5A, 1'b0);
        wait_result(8'h5A, 8'h5A, g, e, l, lat, 1'b1);
        after_done(g, e, l);

        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = WIDTH'($urandom);
                1:       rb = ra;
                default: rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
            endcase
            full_cmp(ra, rb);
        end

        // Comparator asserts gt and lt together on the first slice.
        start_cmp(8'h5A, 8'h5A, 1'b0);
        force_both = 1'b1;
`ifdef CMP_SEQ_CHECK_EN
        exp_err_sticky = 1'b1;
        wait_result(8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        force_both = 1'b0;
        after_done(1'b0, 1'b0, 1'b0);
`else
        wait_result(8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        force_both = 1'b0;
        after_done(1'b1, 1'b0, 1'b0);
`endif
        full_cmp(8'hA7, 8'hA3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
